fb_scan_reader: RTL and testbench
=================================

FB_SCAN_READER -- requirements
Module: fb_scan_reader

Interface
REQ-001 Parameter ROW_LINES, default 4: scanlines per framebuffer row (1..64).
REQ-002 Parameter PIX_CLKS, default 4: clocks per displayed pixel (1..16).
REQ-003 Port clk  input  1: single clock; all state on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port counter  input  3: free-running rotation phase shared with the framebuffer, increments by 1 every clock.
REQ-006 Port frame_start  input  1: one-clock pulse at first line of frame.
REQ-007 Port line_start  input  1: one-clock pulse at start of each line's horizontal blank.
REQ-008 Port active  input  1: high during the 32 visible pixels of a line.
REQ-009 Port palette  input  24: four RGB222 entries, entry k at bits [6k+5:6k].
REQ-010 Port r1_addr, r2_addr  output  4 each: framebuffer read addresses (plane 0, plane 1).
REQ-011 Port data_in1, data_in2  input  32 each: framebuffer read data for r1_addr/r2_addr.
REQ-012 Port rgb  output  6: pixel colour; port underrun  output  1: sticky error flag.

Function
REQ-013 Display is 8 rows x 32 columns, 2 bpp; plane 0 word at address row, plane 1 at row+8; r2_addr SHALL equal {1'b1, r1_addr[2:0]} always.
REQ-014 Line counter resets to 0 on frame_start, increments on each line_start; row = line/ROW_LINES saturating at 7 (lines beyond row 7 display row 7).
REQ-015 States IDLE, WAIT_ALIGN, HOLD, READY; reset state IDLE.
REQ-016 On line_start (any state): r1_addr <= row of the line being started; state <= WAIT_ALIGN.
REQ-017 WAIT_ALIGN -> HOLD on first clock with counter==0; addresses frozen.
REQ-018 HOLD: addresses held stable through counter 0..7; on next clock with counter==0 capture data_in1/data_in2 into shadow registers, state <= READY.
REQ-019 Fetch latency from line_start to READY: 9..16 clocks depending on phase; no other latency permitted.
REQ-020 line_start during WAIT_ALIGN or HOLD aborts and restarts the fetch (REQ-016); shadow registers unchanged.
REQ-021 On first clock of active in READY: shift registers load from shadow, column=0, pixel-clock divider=0.
REQ-022 While active: pixel index = {plane1[column], plane0[column]}, column 0 = bit 0; rgb = palette entry of that index, registered (1-clock latency from shift state).
REQ-023 Column advances every PIX_CLKS clocks; after column 31 completes, rgb = 0 until next line.
REQ-024 active low: rgb = 0; state remains READY until next line_start.
REQ-025 active rising while not READY: rgb = 0 for whole line, underrun <= 1; underrun cleared only by rst or frame_start.
REQ-026 frame_start and line_start same clock: line counter <= 0 then fetch row 0.

Reset
REQ-027 rst asserted: state IDLE, r1_addr 0, r2_addr 8, rgb 0, underrun 0, line counter 0, shadow/shift registers 0, column 0.
REQ-028 rst deassertion mid-line: rgb stays 0 until a full fetch completes after a line_start.

Structure
REQ-029 Shared package holds state encoding, FB_ROWS=8, FB_COLS=32, PLANE1_OFFSET=8, RGB width 6.
REQ-030 One sub-module fb_pixel_shifter: shadow-to-shift load, column/divider counters, palette lookup.

Verification
REQ-031 line_start at counter==3, line 0 -> r1_addr 0, r2_addr 8; READY exactly 13 clocks later; shadow equals words at 0 and 8.
REQ-032 Plane0=0x0000_0001, plane1=0x8000_0000, palette {0x3F,0x30,0x0C,0x03} (k=3..0), PIX_CLKS=4 -> column0 rgb 0x0C for 4 clocks, columns 1..30 0x03, column31 0x30, then 0.
REQ-033 ROW_LINES=4, 40 line_starts after frame_start -> rows 0,0,0,0,1,... saturating at 7 from line 28.
REQ-034 active raised 5 clocks after line_start -> rgb 0 whole line, underrun 1; next frame_start clears it.
REQ-035 Second line_start during HOLD -> new address applied, READY 9..16 clocks after second pulse, old shadow retained meanwhile.
REQ-036 rst pulsed mid-pixel-output -> all outputs at reset values asynchronously; normal output resumes next line.

Source files
------------

// File: rtl/fb_scan_reader_pkg.sv
// Shared constants, fetch-state encoding and palette lookup for the framebuffer scan reader.
package fb_scan_reader_pkg;

  localparam int FB_ROWS       = 8;
  localparam int FB_COLS       = 32;
  localparam int PLANE1_OFFSET = 8;
  localparam int RGB_W         = 6;
  localparam int PAL_W         = 4 * RGB_W;
  localparam int ROW_W         = $clog2(FB_ROWS);
  localparam int COL_W         = $clog2(FB_COLS);
  localparam int ADDR_W        = ROW_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ALIGN,
    HOLD,
    READY
  } FetchState_e;

  function automatic logic [RGB_W-1:0] paletteEntry(input logic [PAL_W-1:0] pal,
                                                     input logic [1:0] idx);
    logic [RGB_W-1:0] entry;
    case (idx)
      2'd0:    entry = pal[0*RGB_W +: RGB_W];
      2'd1:    entry = pal[1*RGB_W +: RGB_W];
      2'd2:    entry = pal[2*RGB_W +: RGB_W];
      default: entry = pal[3*RGB_W +: RGB_W];
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/fb_scan_reader_shifter.sv
// Per-line pixel engine: loads the shadowed plane words, walks the 32 columns at
// PIX_CLKS clocks per pixel and drives the registered palette colour.
module fb_pixel_shifter
  import fb_scan_reader_pkg::*;
#(
  parameter int PIX_CLKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               active_i,
  input  logic [FB_COLS-1:0] shadow0_i,
  input  logic [FB_COLS-1:0] shadow1_i,
  input  logic [PAL_W-1:0]   palette_i,
  output logic [RGB_W-1:0]   rgb_o
);

  localparam int DIV_W = (PIX_CLKS > 1) ? $clog2(PIX_CLKS) : 1;

  logic [FB_COLS-1:0] plane0_q, plane0_d;
  logic [FB_COLS-1:0] plane1_q, plane1_d;
  logic [COL_W-1:0]   column_q, column_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               running_q, running_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic [1:0]         pixelIdx;

  // Bit 0 of each shift register is always the current column; the colour is
  // taken from the present shift state, giving one clock of output latency.
  always_comb begin
    plane0_d  = plane0_q;
    plane1_d  = plane1_q;
    column_d  = column_q;
    div_d     = div_q;
    running_d = running_q;
    pixelIdx  = {plane1_q[0], plane0_q[0]};
    rgb_d     = running_q ? paletteEntry(palette_i, pixelIdx) : '0;

    if (load_i) begin
      plane0_d  = shadow0_i;
      plane1_d  = shadow1_i;
      column_d  = '0;
      div_d     = '0;
      running_d = 1'b1;
    end else if (running_q) begin
      if (!active_i) begin
        running_d = 1'b0;
      end else if (div_q == DIV_W'(PIX_CLKS - 1)) begin
        div_d    = '0;
        plane0_d = plane0_q >> 1;
        plane1_d = plane1_q >> 1;
        column_d = column_q + 1'b1;
        if (column_q == COL_W'(FB_COLS - 1)) begin
          running_d = 1'b0;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plane0_q  <= '0;
      plane1_q  <= '0;
      column_q  <= '0;
      div_q     <= '0;
      running_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      plane0_q  <= plane0_d;
      plane1_q  <= plane1_d;
      column_q  <= column_d;
      div_q     <= div_d;
      running_q <= running_d;
      rgb_q     <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/fb_scan_reader.sv
// Framebuffer scan reader: tracks the display row, fetches both bit planes aligned to
// the shared rotation phase, and hands the shadowed words to the pixel shifter.
module fb_scan_reader
  import fb_scan_reader_pkg::*;
#(
  parameter int ROW_LINES = 4,
  parameter int PIX_CLKS  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         counter,
  input  logic               frame_start,
  input  logic               line_start,
  input  logic               active,
  input  logic [PAL_W-1:0]   palette,
  output logic [ADDR_W-1:0]  r1_addr,
  output logic [ADDR_W-1:0]  r2_addr,
  input  logic [FB_COLS-1:0] data_in1,
  input  logic [FB_COLS-1:0] data_in2,
  output logic [RGB_W-1:0]   rgb,
  output logic               underrun
);

  localparam int SUB_W = (ROW_LINES > 1) ? $clog2(ROW_LINES) : 1;

  FetchState_e        state_q;
  logic [ADDR_W-1:0]  r1Addr_q;
  logic [FB_COLS-1:0] shadow0_q;
  logic [FB_COLS-1:0] shadow1_q;
  logic               underrun_q;
  logic               activePrev_q;
  logic [ROW_W-1:0]   row_q;
  logic [SUB_W-1:0]   subLine_q;

  logic [ROW_W-1:0]   startRow, nextRow;
  logic [SUB_W-1:0]   startSub, nextSub;
  logic               activeRise;
  logic               loadShift;

  // The row/sub-line pair names the line about to start; a coincident
  // frame_start forces that line to be line 0.
  always_comb begin
    startRow = frame_start ? '0 : row_q;
    startSub = frame_start ? '0 : subLine_q;
    nextRow  = startRow;
    nextSub  = startSub + 1'b1;
    if (startSub == SUB_W'(ROW_LINES - 1)) begin
      nextSub = '0;
      if (startRow != ROW_W'(FB_ROWS - 1)) begin
        nextRow = startRow + 1'b1;
      end
    end
  end

  assign activeRise = active && !activePrev_q;
  assign loadShift  = activeRise && (state_q == READY);

  // activePrev_q resets high so a reset released mid-line is not mistaken for a new line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      r1Addr_q     <= '0;
      shadow0_q    <= '0;
      shadow1_q    <= '0;
      underrun_q   <= 1'b0;
      activePrev_q <= 1'b1;
      row_q        <= '0;
      subLine_q    <= '0;
    end else begin
      activePrev_q <= active;

      if (frame_start) begin
        underrun_q <= 1'b0;
      end
      if (activeRise && (state_q != READY)) begin
        underrun_q <= 1'b1;
      end

      if (line_start) begin
        row_q     <= nextRow;
        subLine_q <= nextSub;
      end else if (frame_start) begin
        row_q     <= '0;
        subLine_q <= '0;
      end

      if (line_start) begin
        r1Addr_q <= {1'b0, startRow};
        state_q  <= WAIT_ALIGN;
      end else begin
        case (state_q)
          WAIT_ALIGN: begin
            if (counter == 3'd0) begin
              state_q <= HOLD;
            end
          end
          HOLD: begin
            if (counter == 3'd0) begin
              shadow0_q <= data_in1;
              shadow1_q <= data_in2;
              state_q   <= READY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign r1_addr  = r1Addr_q;
  assign r2_addr  = ADDR_W'(PLANE1_OFFSET) | {1'b0, r1Addr_q[ROW_W-1:0]};
  assign underrun = underrun_q;

  fb_pixel_shifter #(
    .PIX_CLKS(PIX_CLKS)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (loadShift),
    .active_i (active),
    .shadow0_i(shadow0_q),
    .shadow1_i(shadow1_q),
    .palette_i(palette),
    .rgb_o    (rgb)
  );

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed self-checking bench for fb_scan_reader with default parameters.
module tb_fb_scan_reader;
  import fb_scan_reader_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  counter;
  logic        frame_start;
  logic        line_start;
  logic        active;
  logic [23:0] palette;
  logic [3:0]  r1_addr;
  logic [3:0]  r2_addr;
  logic [31:0] data_in1;
  logic [31:0] data_in2;
  logic [5:0]  rgb;
  logic        underrun;

  logic [31:0] fbMem [16];
  int          checkCount;
  int          errorCount;

  fb_scan_reader dut (
    .clk        (clk),
    .rst        (rst),
    .counter    (counter),
    .frame_start(frame_start),
    .line_start (line_start),
    .active     (active),
    .palette    (palette),
    .r1_addr    (r1_addr),
    .r2_addr    (r2_addr),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .rgb        (rgb),
    .underrun   (underrun)
  );

  assign data_in1 = fbMem[r1_addr];
  assign data_in2 = fbMem[r2_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running rotation phase, changed just after each rising edge.
  initial begin
    counter = 3'd0;
    forever begin
      @(posedge clk);
      #1 counter = counter + 3'd1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulseFrameStart();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulseLineStart();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Pulse line_start so that the sampling edge sees counter == c; returns on the following negedge.
  task automatic lineStartAt(input logic [2:0] c);
    for (int i = 0; i < 16 && counter != c; i++) @(negedge clk);
    pulseLineStart();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checkCount += 6;
    if (r1_addr !== 4'h0) begin errorCount++; $display("[TB] FAIL reset_r1: got %h expected 0", r1_addr); end
    if (r2_addr !== 4'h8) begin errorCount++; $display("[TB] FAIL reset_r2: got %h expected 8", r2_addr); end
    if (rgb !== 6'h00) begin errorCount++; $display("[TB] FAIL reset_rgb: got %h expected 00", rgb); end
    if (underrun !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
    if (dut.state_q !== IDLE) begin errorCount++; $display("[TB] FAIL reset_state: got %0d expected IDLE", dut.state_q); end
    if (dut.shadow0_q !== 32'h0) begin errorCount++; $display("[TB] FAIL reset_shadow: got %h expected 0", dut.shadow0_q); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fetch_latency();
    FetchState_e expState;
    pulseFrameStart();
    lineStartAt(3'd3);
    checkCount += 2;
    if (r1_addr !== 4'h0) begin errorCount++; $display("[TB] FAIL fetch_r1: got %h expected 0", r1_addr); end
    if (r2_addr !== 4'h8) begin errorCount++; $display("[TB] FAIL fetch_r2: got %h expected 8", r2_addr); end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      expState = (k < 5) ? WAIT_ALIGN : (k < 13) ? HOLD : READY;
      checkCount++;
      if (dut.state_q !== expState) begin
        errorCount++;
        $display("[TB] FAIL fetch_state clk %0d: got %0d expected %0d", k, dut.state_q, expState);
      end
    end
    checkCount += 2;
    if (dut.shadow0_q !== 32'h0000_0001) begin errorCount++; $display("[TB] FAIL fetch_shadow0: got %h expected 00000001", dut.shadow0_q); end
    if (dut.shadow1_q !== 32'h8000_0000) begin errorCount++; $display("[TB] FAIL fetch_shadow1: got %h expected 80000000", dut.shadow1_q); end
  endtask

  task automatic test_pixel_output();
    logic [5:0] expRgb;
    active = 1'b1;
    for (int j = 0; j <= 132; j++) begin
      @(negedge clk);
      expRgb = (j == 0) ? 6'h00 : (j <= 4) ? 6'h0C : (j <= 124) ? 6'h03 : (j <= 128) ? 6'h30 : 6'h00;
      checkCount++;
      if (rgb !== expRgb) begin
        errorCount++;
        $display("[TB] FAIL pixel_rgb clk %0d: got %h expected %h", j, rgb, expRgb);
      end
      if (j == 127) active = 1'b0;
    end
    checkCount++;
    if (underrun !== 1'b0) begin errorCount++; $display("[TB] FAIL pixel_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_row_mapping();
    int expRow;
    pulseFrameStart();
    for (int i = 0; i < 40; i++) begin
      pulseLineStart();
      expRow = i / 4;
      if (expRow > 7) expRow = 7;
      checkCount += 2;
      if (r1_addr !== 4'(expRow)) begin errorCount++; $display("[TB] FAIL row_r1 line %0d: got %h expected %h", i, r1_addr, 4'(expRow)); end
      if (r2_addr !== 4'(expRow + 8)) begin errorCount++; $display("[TB] FAIL row_r2 line %0d: got %h expected %h", i, r2_addr, 4'(expRow + 8)); end
    end
    frame_start = 1'b1;
    line_start  = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    line_start  = 1'b0;
    checkCount++;
    if (r1_addr !== 4'h0) begin errorCount++; $display("[TB] FAIL row_simul: got %h expected 0", r1_addr); end
    for (int i = 0; i < 3; i++) begin
      pulseLineStart();
      checkCount++;
      if (r1_addr !== 4'h0) begin errorCount++; $display("[TB] FAIL row_after_simul %0d: got %h expected 0", i, r1_addr); end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_underrun();
    pulseFrameStart();
    pulseLineStart();
    repeat (4) @(negedge clk);
    active = 1'b1;
    for (int j = 0; j <= 129; j++) begin
      @(negedge clk);
      checkCount++;
      if (rgb !== 6'h00) begin errorCount++; $display("[TB] FAIL underrun_rgb clk %0d: got %h expected 00", j, rgb); end
      if (j == 127) active = 1'b0;
    end
    checkCount++;
    if (underrun !== 1'b1) begin errorCount++; $display("[TB] FAIL underrun_set: got %b expected 1", underrun); end
    repeat (5) @(negedge clk);
    checkCount++;
    if (underrun !== 1'b1) begin errorCount++; $display("[TB] FAIL underrun_sticky: got %b expected 1", underrun); end
    pulseFrameStart();
    checkCount++;
    if (underrun !== 1'b0) begin errorCount++; $display("[TB] FAIL underrun_clear: got %b expected 0", underrun); end
  endtask

  task automatic test_abort();
    pulseFrameStart();
    repeat (3) pulseLineStart();
    repeat (20) @(negedge clk);
    checkCount += 2;
    if (dut.shadow0_q !== fbMem[0]) begin errorCount++; $display("[TB] FAIL abort_pre_shadow0: got %h expected %h", dut.shadow0_q, fbMem[0]); end
    if (dut.shadow1_q !== fbMem[8]) begin errorCount++; $display("[TB] FAIL abort_pre_shadow1: got %h expected %h", dut.shadow1_q, fbMem[8]); end
    lineStartAt(3'd7);
    @(negedge clk);
    checkCount++;
    if (dut.state_q !== HOLD) begin errorCount++; $display("[TB] FAIL abort_hold: got %0d expected HOLD", dut.state_q); end
    lineStartAt(3'd3);
    checkCount += 3;
    if (r1_addr !== 4'h1) begin errorCount++; $display("[TB] FAIL abort_r1: got %h expected 1", r1_addr); end
    if (r2_addr !== 4'h9) begin errorCount++; $display("[TB] FAIL abort_r2: got %h expected 9", r2_addr); end
    if (dut.shadow0_q !== fbMem[0]) begin errorCount++; $display("[TB] FAIL abort_shadow_kept: got %h expected %h", dut.shadow0_q, fbMem[0]); end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 12) begin
        checkCount += 2;
        if (dut.state_q === READY) begin errorCount++; $display("[TB] FAIL abort_early_ready: got READY expected not READY"); end
        if (dut.shadow0_q !== fbMem[0]) begin errorCount++; $display("[TB] FAIL abort_shadow_hold: got %h expected %h", dut.shadow0_q, fbMem[0]); end
      end
    end
    checkCount += 3;
    if (dut.state_q !== READY) begin errorCount++; $display("[TB] FAIL abort_ready: got %0d expected READY", dut.state_q); end
    if (dut.shadow0_q !== fbMem[1]) begin errorCount++; $display("[TB] FAIL abort_new_shadow0: got %h expected %h", dut.shadow0_q, fbMem[1]); end
    if (dut.shadow1_q !== fbMem[9]) begin errorCount++; $display("[TB] FAIL abort_new_shadow1: got %h expected %h", dut.shadow1_q, fbMem[9]); end
  endtask

  task automatic test_reset_mid_output();
    active = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j == 2) begin
        checkCount++;
        if (rgb !== 6'h03) begin errorCount++; $display("[TB] FAIL midrst_col0: got %h expected 03", rgb); end
      end
      if (j == 6) begin
        checkCount++;
        if (rgb !== 6'h0C) begin errorCount++; $display("[TB] FAIL midrst_col1: got %h expected 0C", rgb); end
      end
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkCount += 5;
    if (rgb !== 6'h00) begin errorCount++; $display("[TB] FAIL midrst_rgb: got %h expected 00", rgb); end
    if (r1_addr !== 4'h0) begin errorCount++; $display("[TB] FAIL midrst_r1: got %h expected 0", r1_addr); end
    if (r2_addr !== 4'h8) begin errorCount++; $display("[TB] FAIL midrst_r2: got %h expected 8", r2_addr); end
    if (underrun !== 1'b0) begin errorCount++; $display("[TB] FAIL midrst_underrun: got %b expected 0", underrun); end
    if (dut.state_q !== IDLE) begin errorCount++; $display("[TB] FAIL midrst_state: got %0d expected IDLE", dut.state_q); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      checkCount++;
      if (rgb !== 6'h00) begin errorCount++; $display("[TB] FAIL midrst_rest_rgb clk %0d: got %h expected 00", j, rgb); end
    end
    active = 1'b0;
    @(negedge clk);
    checkCount++;
    if (underrun !== 1'b0) begin errorCount++; $display("[TB] FAIL midrst_no_underrun: got %b expected 0", underrun); end
    pulseFrameStart();
    pulseLineStart();
    repeat (17) @(negedge clk);
    active = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) begin
        checkCount++;
        if (rgb !== 6'h0C) begin errorCount++; $display("[TB] FAIL resume_col0: got %h expected 0C", rgb); end
      end
      if (j == 5) begin
        checkCount++;
        if (rgb !== 6'h03) begin errorCount++; $display("[TB] FAIL resume_col1: got %h expected 03", rgb); end
      end
    end
    active = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    rst         = 1'b1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    active      = 1'b0;
    palette     = {6'h3F, 6'h30, 6'h0C, 6'h03};
    for (int i = 0; i < 16; i++) fbMem[i] = {8{4'(i)}};
    fbMem[0] = 32'h0000_0001;
    fbMem[8] = 32'h8000_0000;
    fbMem[1] = 32'hA5A5_5A5A;
    fbMem[9] = 32'h1234_5678;

    test_reset();
    test_fetch_latency();
    test_pixel_output();
    test_row_mapping();
    test_underrun();
    test_abort();
    test_reset_mid_output();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
